// File: rtl/sw_max_score_tracker_pkg.sv
// Shared widths and FSM state encoding for the
// Smith-Waterman max-score tracker.
package sw_max_score_tracker_pkg;

    localparam int V_E_F_BIT = 17;
    localparam int MAX_T_BIT = 14;
    localparam int LANES_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sw_max_score_tracker_if.sv
// Score beat stream from the PE array into the tracker.
// The array side is master, the tracker is slave.
interface sw_max_score_tracker_if
    import sw_max_score_tracker_pkg::*;
#(
    parameter int DATA_WIDTH = V_E_F_BIT,
    parameter int LANES      = LANES_DEF
);

    logic                          i_valid;
    logic                          o_ready;
    logic [DATA_WIDTH*LANES-1:0]   i_data;
    logic                          i_last;

    modport master (
        output i_valid,
        output i_data,
        output i_last,
        input  o_ready
    );

    modport slave (
        input  i_valid,
        input  i_data,
        input  i_last,
        output o_ready
    );

endinterface

// File: rtl/sw_max_score_tracker_lane_max.sv
// Combinational max over one beat of lanes.
// Negative scores clamp to zero; ties keep the lowest lane.
module sw_lane_max_idx #(
    parameter int DATA_WIDTH = 17,
    parameter int LANES      = 8,
    parameter int LANE_W     = 3
) (
    input  logic [DATA_WIDTH*LANES-1:0] data,
    output logic [DATA_WIDTH-2:0]       max_val,
    output logic [LANE_W-1:0]           max_lane
);

    logic [DATA_WIDTH-2:0] cand;

    // Scan lanes upward; strict compare keeps the first lane on ties.
    always_comb begin
        max_val  = '0;
        max_lane = '0;
        cand     = '0;
        for (int k = 0; k < LANES; k++) begin
            if (data[k*DATA_WIDTH + DATA_WIDTH - 1]) begin
                cand = '0;
            end else begin
                cand = data[k*DATA_WIDTH +: DATA_WIDTH-1];
            end
            if (cand > max_val) begin
                max_val  = cand;
                max_lane = LANE_W'(k);
            end
        end
    end

endmodule

// File: rtl/sw_max_score_tracker.sv
// Global max-score tracker: registered lane max, then a
// running-max accumulator, sequenced by a small run FSM.
module sw_max_score_tracker
    import sw_max_score_tracker_pkg::*;
#(
    parameter int DATA_WIDTH = V_E_F_BIT,
    parameter int LANES      = LANES_DEF,
    parameter int IDX_WIDTH  = MAX_T_BIT,
    parameter int LANE_W     = $clog2(LANES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sw_max_score_tracker_if.slave bus,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_max,
    output logic [IDX_WIDTH-1:0]  o_max_beat,
    output logic [LANE_W-1:0]     o_max_lane,
    output logic                  o_overflow
);

    localparam logic [IDX_WIDTH-1:0] BEAT_MAX = '1;

    state_t                state;
    logic                  drain_cnt;
    logic                  ready_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  accept;
    logic                  start_ok;

    logic [DATA_WIDTH-2:0] lm_val;
    logic [LANE_W-1:0]     lm_lane;

    logic                  s1_valid;
    logic [DATA_WIDTH-2:0] s1_val;
    logic [LANE_W-1:0]     s1_lane;
    logic [IDX_WIDTH-1:0]  s1_beat;

    logic [IDX_WIDTH-1:0]  beat_cnt;
    logic                  ovf_q;
    logic [DATA_WIDTH-2:0] max_val;
    logic [IDX_WIDTH-1:0]  max_beat;
    logic [LANE_W-1:0]     max_lane;

    assign accept   = bus.i_valid & ready_q;
    assign start_ok = i_start & ((state == ST_IDLE) | (state == ST_DONE));

    sw_lane_max_idx #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES),
        .LANE_W     (LANE_W)
    ) u_lane_max (
        .data     (bus.i_data),
        .max_val  (lm_val),
        .max_lane (lm_lane)
    );

    // Run sequencing with registered ready/busy/done outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            drain_cnt <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state   <= ST_RUN;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (accept && bus.i_last) begin
                        state     <= ST_DRAIN;
                        ready_q   <= 1'b0;
                        drain_cnt <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (i_start) begin
                        state   <= ST_RUN;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stage 1 captures the beat max; stage 2 folds it into the running max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_val   <= '0;
            s1_lane  <= '0;
            s1_beat  <= '0;
            beat_cnt <= '0;
            ovf_q    <= 1'b0;
            max_val  <= '0;
            max_beat <= '0;
            max_lane <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_val  <= lm_val;
                s1_lane <= lm_lane;
                s1_beat <= beat_cnt;
            end
            if (start_ok) begin
                beat_cnt <= '0;
                ovf_q    <= 1'b0;
                max_val  <= '0;
                max_beat <= '0;
                max_lane <= '0;
            end else begin
                // The count sticks at all-ones; later beats share that tag.
                if (accept) begin
                    if (beat_cnt == BEAT_MAX) begin
                        ovf_q <= 1'b1;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                if (s1_valid && (s1_val > max_val)) begin
                    max_val  <= s1_val;
                    max_beat <= s1_beat;
                    max_lane <= s1_lane;
                end
            end
        end
    end

    assign bus.o_ready = ready_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_max       = {1'b0, max_val};
    assign o_max_beat  = max_beat;
    assign o_max_lane  = max_lane;
    assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_sw_max_score_tracker.sv
// Directed plus random bench for sw_max_score_tracker, run on a
// full-width instance and a 4-bit beat-index instance in parallel.
module tb_sw_max_score_tracker;

    localparam int DW = 17;
    localparam int NL = 8;
    localparam int BW = DW * NL;
    localparam logic [BW-1:0] JUNK = {NL{17'h0FFFF}};

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          valid;
    logic [BW-1:0] data;
    logic          last;

    logic          busy_a, done_a, ov_a;
    logic [DW-1:0] max_a;
    logic [13:0]   beat_a;
    logic [2:0]    lane_a;

    logic          busy_b, done_b, ov_b;
    logic [DW-1:0] max_b;
    logic [3:0]    beat_b;
    logic [2:0]    lane_b;

    logic          ready_a, ready_b;

    int errors = 0;
    int checks = 0;

    logic [BW-1:0] beats[$];

    sw_max_score_tracker_if #(.DATA_WIDTH(DW), .LANES(NL)) bus_a ();
    sw_max_score_tracker_if #(.DATA_WIDTH(DW), .LANES(NL)) bus_b ();

    assign bus_a.i_valid = valid;
    assign bus_a.i_data  = data;
    assign bus_a.i_last  = last;
    assign bus_b.i_valid = valid;
    assign bus_b.i_data  = data;
    assign bus_b.i_last  = last;
    assign ready_a       = bus_a.o_ready;
    assign ready_b       = bus_b.o_ready;

    sw_max_score_tracker #(
        .DATA_WIDTH (DW),
        .LANES      (NL),
        .IDX_WIDTH  (14),
        .LANE_W     (3)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_a),
        .i_start    (start),
        .o_busy     (busy_a),
        .o_done     (done_a),
        .o_max      (max_a),
        .o_max_beat (beat_a),
        .o_max_lane (lane_a),
        .o_overflow (ov_a)
    );

    sw_max_score_tracker #(
        .DATA_WIDTH (DW),
        .LANES      (NL),
        .IDX_WIDTH  (4),
        .LANE_W     (3)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_b),
        .i_start    (start),
        .o_busy     (busy_b),
        .o_done     (done_b),
        .o_max      (max_b),
        .o_max_beat (beat_b),
        .o_max_lane (lane_b),
        .o_overflow (ov_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: first strictly-greater clamped score in beat-major,
    // lane-minor order; beat tags saturate at 2^iw-1.
    task automatic model(input int iw, output logic [63:0] mx,
                         output logic [63:0] mb, output logic [63:0] ml,
                         output logic [63:0] ov);
        int best, bb, bl, maxi, m;
        logic [BW-1:0] w;
        logic [DW-1:0] v;
        best = 0; bb = 0; bl = 0;
        maxi = (1 << iw) - 1;
        for (int b = 0; b < beats.size(); b++) begin
            w = beats[b];
            for (int l = 0; l < NL; l++) begin
                v = w[l*DW +: DW];
                m = v[DW-1] ? 0 : int'(v[DW-2:0]);
                if (m > best) begin
                    best = m;
                    bb = (b > maxi) ? maxi : b;
                    bl = l;
                end
            end
        end
        mx = 64'(best);
        mb = 64'(bb);
        ml = 64'(bl);
        ov = (beats.size() > maxi) ? 64'd1 : 64'd0;
    endtask

    function automatic logic [BW-1:0] rand_beat(input int range);
        logic [BW-1:0] w;
        logic [DW-1:0] v;
        w = '0;
        for (int l = 0; l < NL; l++) begin
            v[DW-1]   = ($urandom_range(3) == 0);
            v[DW-2:0] = 16'($urandom_range(range));
            w[l*DW +: DW] = v;
        end
        return w;
    endfunction

    function automatic logic [BW-1:0] one_lane(input int lane,
                                               input logic [DW-1:0] val);
        logic [BW-1:0] w;
        w = '0;
        w[lane*DW +: DW] = val;
        return w;
    endfunction

    // Caller sits just after a negedge with the DUTs in IDLE, DONE or RUN.
    task automatic do_run(input string tag, input int bubble_pct,
                          input bit chain);
        logic [63:0] am, ab, al, ao, bm, bb, bl, bo;
        int first_a, first_b, cnt_a, cnt_b;
        model(14, am, ab, al, ao);
        model(4, bm, bb, bl, bo);
        first_a = 0; first_b = 0; cnt_a = 0; cnt_b = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " ready_run"}, 64'(ready_a), 64'd1);
        check({tag, " busy_run"}, 64'(busy_a), 64'd1);
        for (int b = 0; b < beats.size(); b++) begin
            if ($urandom_range(99) < bubble_pct) begin
                valid = 1'b0;
                data  = JUNK;
                last  = 1'b1;
                @(negedge clk);
            end
            valid = 1'b1;
            data  = beats[b];
            last  = (b == beats.size() - 1);
            @(negedge clk);
        end
        for (int c = 1; c <= 6; c++) begin
            if (c == 1) begin
                check({tag, " ready_drain"}, 64'(ready_a), 64'd0);
                check({tag, " busy_drain"}, 64'(busy_b), 64'd1);
            end
            if (c == 2) begin
                check({tag, " max_lat_a"}, 64'(max_a), am);
                check({tag, " max_lat_b"}, 64'(max_b), bm);
            end
            if (c == 3) begin
                check({tag, " max_a"}, 64'(max_a), am);
                check({tag, " beat_a"}, 64'(beat_a), ab);
                check({tag, " lane_a"}, 64'(lane_a), al);
                check({tag, " ovf_a"}, 64'(ov_a), ao);
                check({tag, " max_b"}, 64'(max_b), bm);
                check({tag, " beat_b"}, 64'(beat_b), bb);
                check({tag, " lane_b"}, 64'(lane_b), bl);
                check({tag, " ovf_b"}, 64'(ov_b), bo);
            end
            if (done_a) begin
                cnt_a++;
                if (first_a == 0) first_a = c;
            end
            if (done_b) begin
                cnt_b++;
                if (first_b == 0) first_b = c;
            end
            valid = (c < 3);
            data  = JUNK;
            last  = 1'b1;
            start = chain && (c == 3);
            @(negedge clk);
        end
        start = 1'b0;
        valid = 1'b0;
        check({tag, " done_lat_a"}, 64'(first_a), 64'd3);
        check({tag, " done_len_a"}, 64'(cnt_a), 64'd1);
        check({tag, " done_lat_b"}, 64'(first_b), 64'd3);
        check({tag, " done_len_b"}, 64'(cnt_b), 64'd1);
        if (chain) begin
            check({tag, " chain_busy"}, 64'(busy_a), 64'd1);
            check({tag, " chain_ready"}, 64'(ready_a), 64'd1);
            check({tag, " chain_clr"}, 64'(max_a), 64'd0);
        end
    endtask

    initial begin
        int done_seen;
        int len;
        int range;
        rst_n = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        data  = '0;
        last  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst max", 64'(max_a), 64'd0);
        check("rst beat", 64'(beat_a), 64'd0);
        check("rst lane", 64'(lane_a), 64'd0);
        check("rst ovf", 64'(ov_a), 64'd0);
        check("rst ready", 64'(ready_a), 64'd0);
        check("rst busy", 64'(busy_a), 64'd0);
        check("rst done", 64'(done_a), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic three-beat run.
        beats.delete();
        beats.push_back(one_lane(2, 17'h00010));
        beats.push_back(one_lane(5, 17'h00040));
        beats.push_back({NL{17'h00005}});
        do_run("basic", 0, 1'b0);
        check("basic k_max", 64'(max_a), 64'h40);
        check("basic k_beat", 64'(beat_a), 64'd1);
        check("basic k_lane", 64'(lane_a), 64'd5);
        check("hold ready", 64'(ready_a), 64'd0);

        // Ties within a beat and across beats.
        beats.delete();
        beats.push_back(one_lane(3, 17'h00100) | one_lane(6, 17'h00100));
        for (int i = 1; i < 4; i++) beats.push_back(one_lane(i, 17'h00020));
        beats.push_back(one_lane(0, 17'h00100));
        do_run("ties", 0, 1'b0);
        check("ties k_lane", 64'(lane_a), 64'd3);

        // Negatives clamp to zero, then one large positive.
        beats.delete();
        beats.push_back({NL{17'h1FFFF}});
        beats.push_back({NL{17'h1FFFF}});
        do_run("neg", 0, 1'b0);
        check("neg k_max", 64'(max_a), 64'd0);
        beats.delete();
        beats.push_back({NL{17'h1FFFF}});
        beats.push_back({{17'h0FFFF}, {(NL-1){17'h1FFFF}}});
        do_run("neg2", 0, 1'b0);
        check("neg2 k_max", 64'(max_a), 64'h0FFFF);

        // Bubbles before every beat.
        beats.delete();
        beats.push_back(one_lane(1, 17'h00011));
        beats.push_back(one_lane(7, 17'h00022));
        beats.push_back(one_lane(4, 17'h00033));
        do_run("bubble", 100, 1'b0);
        check("bubble k_beat", 64'(beat_a), 64'd2);

        // Beat index saturation on the narrow instance.
        beats.delete();
        for (int i = 0; i < 20; i++) begin
            if (i == 18) beats.push_back(one_lane(1, 17'h00777));
            else beats.push_back(rand_beat(16'h0700));
        end
        do_run("ovf", 20, 1'b0);
        check("ovf k_ovb", 64'(ov_b), 64'd1);
        check("ovf k_beatb", 64'(beat_b), 64'd15);
        check("ovf k_beata", 64'(beat_a), 64'd18);

        // Asynchronous reset in the middle of a run.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        valid = 1'b1;
        data  = {NL{17'h00123}};
        last  = 1'b0;
        @(negedge clk);
        data  = {NL{17'h00456}};
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        check("pre_rst max", 64'(max_a), 64'h456);
        rst_n = 1'b0;
        #1;
        check("mid_rst max", 64'(max_a), 64'd0);
        check("mid_rst beat", 64'(beat_a), 64'd0);
        check("mid_rst ready", 64'(ready_a), 64'd0);
        check("mid_rst busy", 64'(busy_a), 64'd0);
        check("mid_rst max_b", 64'(max_b), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done_a || done_b) done_seen++;
        end
        check("mid_rst no_done", 64'(done_seen), 64'd0);
        beats.delete();
        beats.push_back(one_lane(6, 17'h00abc));
        do_run("single", 0, 1'b0);

        // Random runs; one ends with a start during DONE.
        for (int r = 0; r < 8; r++) begin
            beats.delete();
            len   = $urandom_range(1, 12);
            range = ($urandom_range(1) == 0) ? 63 : 65535;
            for (int i = 0; i < len; i++) beats.push_back(rand_beat(range));
            do_run($sformatf("rnd%0d", r), 30, (r == 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sw_max_score_tracker.md
Name: sw_max_score_tracker

Overview:
- Downstream of the PE array; consumes the stream of cell scores (V values) the array emits, LANES values per beat.
- Finds the global maximum alignment score of one query/database run and the beat/lane where it first occurred.
- Reports the result for traceback and readout.
- Built around a registered lane-max-with-index reduction plus a running-max accumulator under a small control FSM.

Parameters:
- DATA_WIDTH, 17 (`V_E_F_Bit): score width; MSB is the sign flag, the lower DATA_WIDTH-1 bits are the magnitude.
- LANES, 8: scores per input beat; power of two.
- IDX_WIDTH, 14 (`Max_T_bit): beat counter width.
- LANE_W, 3: log2(LANES).

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- i_start, in, 1: begin a run; sampled in IDLE/DONE only.
- i_valid, in, 1: beat valid.
- o_ready, out, 1: tracker accepts a beat; a beat transfers when i_valid & o_ready.
- i_data, in, DATA_WIDTH*LANES: lane k is at bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_last, in, 1: the accepted beat is the final one of the run.
- o_busy, out, 1: high in RUN/DRAIN.
- o_done, out, 1: one-cycle pulse when the result is final.
- o_max, out, DATA_WIDTH: maximum score; sign bit is always 0.
- o_max_beat, out, IDX_WIDTH: beat index of the first occurrence of o_max.
- o_max_lane, out, LANE_W: lane index of the first occurrence of o_max.
- o_overflow, out, 1: the beat count exceeded 2^IDX_WIDTH-1 during the run.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; o_ready, o_busy, o_done, o_overflow = 0; o_max, o_max_beat, o_max_lane = 0; pipeline valids cleared. This applies mid-run too: any partial result is discarded.
- Negative input (MSB=1) is treated as value 0. Comparison is unsigned on the magnitude bits.
- States:
  - IDLE: o_ready=0. i_start -> RUN.
  - RUN: o_ready=1. On i_start entry, clear the running max to 0, the index to (0,0), the beat counter to 0 and o_overflow. On an accepted beat with i_last=1 -> DRAIN.
  - DRAIN: o_ready=0 for 2 cycles (pipeline flush), then -> DONE.
  - DONE: o_done=1 for exactly one cycle, then -> IDLE.
- Results hold until the next i_start.
- i_start in RUN/DRAIN is ignored. i_start in DONE is accepted, giving DONE->RUN directly; o_done still pulses that cycle.
- Pipeline:
  - Stage 1 (registered): lane-max of the beat with its lowest lane index on ties, plus the beat index and a valid bit.
  - Stage 2 (registered): if stage-1 max > running max (strictly greater), update o_max, o_max_beat and o_max_lane. Ties keep the earlier beat.
  - Latency from an accepted beat to o_max visible: 2 cycles.
  - o_done asserts 3 cycles after the last-beat acceptance and coincides with the final result being stable.
- Beat counter: increments per accepted beat. At 2^IDX_WIDTH-1 it saturates, and o_overflow is set sticky for the run. Later beats still participate in the max, tagged with the saturated index.
- An all-zero or all-negative run gives o_max=0, beat=0, lane=0.
- A single-beat run (first beat carries i_last) is legal.
- i_valid while o_ready=0 is ignored; the stimulus must hold the beat.

Decomposition:
- Shared package/header: `V_E_F_Bit, `Max_T_bit, LANES default, and state encodings (IDLE=0, RUN=1, DRAIN=2, DONE=3).
- One sub-module, sw_lane_max_idx: combinational LANES-input sign-clamped max tree returning value and lowest lane index. The tracker registers its output as stage 1.

Test Plan:
- Basic: start, 3 beats with lane values {beat0 lane2=0x00010, beat1 lane5=0x00040, beat2 all 0x00005}, last on beat2 -> o_done 3 cycles after beat2; o_max=0x00040, beat=1, lane=5, o_overflow=0.
- Ties: beat0 lanes 3 and 6 = 0x00100, beat4 lane0 = 0x00100 -> o_max=0x00100, beat=0, lane=3.
- Negatives: all lanes 0x1FFFF (negative) for 2 beats -> o_max=0, beat=0, lane=0. Then rerun with one 0x0FFFF value -> o_max=0x0FFFF.
- Backpressure/bubbles: i_valid toggled 1,0,1,0 and i_valid asserted during DRAIN -> only beats with o_ready=1 are counted. The beat index skips bubbles (3 accepted beats -> indices 0..2).
- Overflow (IDX_WIDTH overridden to 4): 20 beats, max 0x00777 in beat 18 lane 1 -> o_overflow=1, o_max_beat=15, lane=1.
- Async reset mid-RUN after 2 beats -> all outputs 0 immediately, state IDLE, no o_done. A new start and a single-beat run then give the correct result.
